// File: rtl/multi_opll_bridge_pkg.sv
// Shared types and defaults for the multi-OPLL bus bridge.
package opll_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int unsigned DEF_ADDR_WAIT = 12;
  localparam int unsigned DEF_DATA_WAIT = 84;

  typedef struct packed {
    logic       a0;
    logic [7:0] d;
  } fifo_entry_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/multi_opll_bridge_if.sv
// Cartridge-side request bus: one write/read request per cycle, combinational ready.
interface multi_opll_bridge_if;
  logic        memreq;
  logic        ioreq;
  logic [15:0] address;
  logic        write;
  logic        valid;
  logic        ready;
  logic [7:0]  wdata;

  modport master (output memreq, ioreq, address, write, valid, wdata, input ready);
  modport slave  (input memreq, ioreq, address, write, valid, wdata, output ready);
endinterface

// File: rtl/multi_opll_bridge_queue.sv
// Per-chip write queue: FIFO of pending register writes replayed to one OPLL,
// each followed by the chip's access-wait counted in enable pulses.
module opll_write_queue
  import opll_bridge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WAIT  = DEF_ADDR_WAIT,
  parameter int unsigned DATA_WAIT  = DEF_DATA_WAIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        i_push,
  input  fifo_entry_t i_entry,
  output logic        o_full,
  output logic        o_cs_n,
  output logic        o_wr_n,
  output logic        o_a0,
  output logic [7:0]  o_d
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(max_u(ADDR_WAIT, DATA_WAIT) + 1);

  fifo_entry_t    r_mem [FIFO_DEPTH];
  logic [PW-1:0]  r_wptr, r_rptr;
  logic [PW-1:0]  w_count;
  logic           w_empty, w_push, w_pop;
  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic           r_a0;
  logic [7:0]     r_d;

  // Fullness comes from the registered pointers only, so a same-cycle pop never frees a slot.
  assign w_count = r_wptr - r_rptr;
  assign w_empty = (w_count == '0);
  assign o_full  = (w_count == PW'(FIFO_DEPTH));
  assign w_push  = i_push & ~o_full;
  assign o_a0    = r_a0;
  assign o_d     = r_d;

  // Entry storage; contents are don't-care until the write pointer covers them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_entry;
  end

  // Next-state, pop request and chip strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    o_cs_n      = 1'b1;
    o_wr_n      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_cs_n = 1'b0;
        o_wr_n = 1'b0;
        if (enable) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = r_a0 ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else if (enable) begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, pacing counter, FIFO pointers and the held write presented to the chip.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_a0    <= 1'b0;
      r_d     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
        r_a0   <= r_mem[r_rptr[AW-1:0]].a0;
        r_d    <= r_mem[r_rptr[AW-1:0]].d;
      end
    end
  end

endmodule

// File: rtl/multi_opll_bridge.sv
// Bus front-end for N OPLL cores: address decode, write queuing per chip,
// and a saturating mixer of the chip sound outputs.
module multi_opll_bridge
  import opll_bridge_pkg::*;
#(
  parameter int unsigned           N_CHIP     = 2,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [N_CHIP*8-1:0]   IO_BASE    = {8'h7A, 8'h7C},
  parameter logic [N_CHIP*16-1:0]  MEM_BASE   = {16'h7FF2, 16'h7FF4},
  parameter int unsigned           ADDR_WAIT  = DEF_ADDR_WAIT,
  parameter int unsigned           DATA_WAIT  = DEF_DATA_WAIT,
  parameter int unsigned           MIX_SHIFT  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  multi_opll_bridge_if.slave    bus,
  output logic [N_CHIP-1:0]     opll_cs_n,
  output logic [N_CHIP-1:0]     opll_wr_n,
  output logic [N_CHIP-1:0]     opll_a0,
  output logic [8*N_CHIP-1:0]   opll_d,
  input  logic [16*N_CHIP-1:0]  sound_in,
  output logic [15:0]           sound_mix,
  output logic                  mix_sat
);

  localparam int unsigned SW = 16 + $clog2(N_CHIP);
  localparam logic signed [SW-1:0] SAT_HI = SW'(32767);
  localparam logic signed [SW-1:0] SAT_LO = SW'(-32768);

  logic [N_CHIP-1:0]     w_hit, w_sel, w_full, w_push;
  logic                  w_found;
  fifo_entry_t           w_entry;
  logic signed [SW-1:0]  w_sum;
  logic [15:0]           w_mix_nxt;
  logic                  w_sat_nxt;
  logic [15:0]           r_mix;
  logic                  r_sat;

  // Address decode with lowest-index priority when several chips match.
  always_comb begin
    w_hit   = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N_CHIP; i++) begin
      w_hit[i] = (bus.ioreq  && (bus.address[7:1]  == IO_BASE[8*i+1 +: 7])) ||
                 (bus.memreq && (bus.address[15:1] == MEM_BASE[16*i+1 +: 15]));
      if (w_hit[i] && !w_found) begin
        w_sel[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  assign w_push    = {N_CHIP{bus.valid & bus.write}} & w_sel & ~w_full;
  assign bus.ready = ~(bus.valid & bus.write & (|(w_sel & w_full)));
  assign w_entry   = '{a0: bus.address[0], d: bus.wdata};

  for (genvar g = 0; g < N_CHIP; g++) begin : g_chip
    opll_write_queue #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .ADDR_WAIT (ADDR_WAIT),
      .DATA_WAIT (DATA_WAIT)
    ) u_queue (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .i_push (w_push[g]),
      .i_entry(w_entry),
      .o_full (w_full[g]),
      .o_cs_n (opll_cs_n[g]),
      .o_wr_n (opll_wr_n[g]),
      .o_a0   (opll_a0[g]),
      .o_d    (opll_d[8*g +: 8])
    );
  end

  // Widened signed sum of the pre-shifted chip outputs, clamped to 16 bits.
  always_comb begin
    w_sum     = '0;
    w_mix_nxt = '0;
    w_sat_nxt = 1'b0;
    for (int unsigned i = 0; i < N_CHIP; i++) begin
      w_sum = w_sum + SW'($signed(sound_in[16*i +: 16]) >>> MIX_SHIFT);
    end
    if (w_sum > SAT_HI) begin
      w_mix_nxt = 16'h7FFF;
      w_sat_nxt = 1'b1;
    end else if (w_sum < SAT_LO) begin
      w_mix_nxt = 16'h8000;
      w_sat_nxt = 1'b1;
    end else begin
      w_mix_nxt = w_sum[15:0];
    end
  end

  // Mix output updates on enable pulses; the saturation flag lasts one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mix <= '0;
      r_sat <= 1'b0;
    end else begin
      r_sat <= enable & w_sat_nxt;
      if (enable) r_mix <= w_mix_nxt;
    end
  end

  assign sound_mix = r_mix;
  assign mix_sat   = r_sat;

endmodule
